memory_stage: RTL

//  Pipeline stage directly after execute. Performs the data-memory access for loads/stores over the dbus.
//  It aligns store data and byte strobes, and sign/zero-extends load data.
//  It stalls execute while a bus transaction is outstanding and registers the result toward writeback.
//  An in-flight bus request survives a pipeline flush through a DRAIN state; the bus protocol cannot abort.

---
 rtl/memory_stage.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues dbus loads/stores, aligns store lanes, extends load data,
// stalls execute while a request is outstanding and registers the result toward writeback.
module memory_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  input  logic [1:0]      in_mem_op,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_dst,
  input  logic            in_wen,
  output logic            stall,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_dst,
  output logic            out_wen,
  output logic [XLEN-1:0] out_result,
  output logic            out_error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]      state_reg, state_next;
  logic [XLEN-1:0] addr_reg;
  logic [2:0]      funct3_reg;
  logic [7:0]      strobe_reg;
  logic [XLEN-1:0] data_reg;
  logic            load_reg;
  logic            latch_en;

  logic            is_load, is_store, mem_op, misaligned, mem;
  logic [7:0]      size_mask, in_strobe;
  logic [XLEN-1:0] in_sdata;

  logic            complete, comp_wen, comp_error;
  logic [XLEN-1:0] comp_result;

  // Lane select then extend; funct3[2] selects zero extension.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                  input logic [2:0] f3,
                                                  input logic [2:0] off);
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] res;
    lane = raw >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{56{lane[7]}}, lane[7:0]};
      3'b001:  res = {{48{lane[15]}}, lane[15:0]};
      3'b010:  res = {{32{lane[31]}}, lane[31:0]};
      3'b100:  res = {56'd0, lane[7:0]};
      3'b101:  res = {48'd0, lane[15:0]};
      3'b110:  res = {32'd0, lane[31:0]};
      default: res = lane;
    endcase
    return res;
  endfunction

  always_comb begin
    is_load  = (in_mem_op == 2'b01);
    is_store = (in_mem_op == 2'b10);
    mem_op   = in_valid && (is_load || is_store);
    case (in_funct3[1:0])
      2'd1:    misaligned = in_addr[0];
      2'd2:    misaligned = (in_addr[1:0] != 2'd0);
      2'd3:    misaligned = (in_addr[2:0] != 3'd0);
      default: misaligned = 1'b0;
    endcase
    mem = mem_op && !misaligned;
    case (in_funct3[1:0])
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    in_strobe = is_store ? (size_mask << in_addr[2:0]) : 8'h00;
    in_sdata  = in_wdata << {in_addr[2:0], 3'b000};
  end

  always_comb begin
    state_next  = state_reg;
    stall       = 1'b0;
    latch_en    = 1'b0;
    dreq_valid  = 1'b0;
    dreq_addr   = addr_reg;
    dreq_size   = {1'b0, funct3_reg[1:0]};
    dreq_strobe = strobe_reg;
    dreq_data   = data_reg;
    complete    = 1'b0;
    comp_wen    = in_wen;
    comp_error  = 1'b0;
    comp_result = in_addr;
    case (state_reg)
      IDLE: begin
        if (in_valid && !flush) begin
          if (mem) begin
            dreq_valid  = 1'b1;
            dreq_addr   = in_addr;
            dreq_size   = {1'b0, in_funct3[1:0]};
            dreq_strobe = in_strobe;
            dreq_data   = in_sdata;
            latch_en    = 1'b1;
            if (dresp_data_ok) begin
              complete = 1'b1;
              comp_wen = is_load && in_wen;
              if (is_load)
                comp_result = extend_load(dresp_data, in_funct3, in_addr[2:0]);
            end else begin
              stall      = 1'b1;
              state_next = WAIT;
            end
          end else if (mem_op) begin
            complete   = 1'b1;
            comp_error = 1'b1;
            comp_wen   = 1'b0;
          end else begin
            complete = 1'b1;
          end
        end
      end
      WAIT: begin
        dreq_valid = 1'b1;
        if (dresp_data_ok) begin
          state_next = IDLE;
          if (!flush) begin
            complete = 1'b1;
            comp_wen = load_reg && in_wen;
            if (load_reg)
              comp_result = extend_load(dresp_data, funct3_reg, addr_reg[2:0]);
          end
        end else begin
          stall = 1'b1;
          if (flush)
            state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The bus cannot abort: keep the request up until it completes, then drop the data.
        dreq_valid = 1'b1;
        if (dresp_data_ok)
          state_next = IDLE;
        else
          stall = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      funct3_reg <= '0;
      strobe_reg <= '0;
      data_reg   <= '0;
      load_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (latch_en) begin
        addr_reg   <= in_addr;
        funct3_reg <= in_funct3;
        strobe_reg <= in_strobe;
        data_reg   <= in_sdata;
        load_reg   <= is_load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_dst    <= '0;
      out_wen    <= 1'b0;
      out_result <= '0;
      out_error  <= 1'b0;
    end else if (complete && !flush) begin
      out_valid  <= 1'b1;
      out_pc     <= in_pc;
      out_dst    <= in_dst;
      out_wen    <= comp_wen;
      out_result <= comp_result;
      out_error  <= comp_error;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
